// File: rtl/sprite_mem_pkg.sv
// Shared types and defaults for the sprite memory bank.
// Clear engine state encoding plus pixel width/defaults.
package sprite_mem_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 10;

  localparam logic [DATA_W_DEF-1:0] PIXEL_BLACK = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

endpackage

// File: rtl/sprite_clear_fsm.sv
// Background clear engine: walks one bank writing the fill word.
// Ports: i_Clk, i_Rst, i_clear_req/i_clear_sel in; o_clr_* write, o_busy, o_done out.
module sprite_clear_fsm
  import sprite_mem_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_clear_req,
  input  logic [SEL_W-1:0]  i_clear_sel,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic [SEL_W-1:0]  o_clr_sel,
  output logic              o_busy,
  output logic              o_done
);

  clear_state_t      r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic              r_busy;
  logic              r_done;
  logic              w_sel_ok;

  assign w_sel_ok = int'(i_clear_sel) < NUM_SPRITES;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_clear_req && w_sel_ok) begin
            r_sel   <= i_clear_sel;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          // last word written this cycle; counter stays put
          if (&r_cnt) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_cnt;
  assign o_clr_sel  = r_sel;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: rtl/sprite_mem_bank.sv
// Multi-bank sprite pixel store with registered read and bank clear.
// Ports: write (en/sel/addr/data), read (en/sel/addr -> data/valid), clear (req/sel -> busy/done).
module sprite_mem_bank
  import sprite_mem_pkg::*;
#(
  parameter int                NUM_SPRITES = 4,
  parameter int                SEL_W       = 2,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL_VALUE  = DATA_W'(PIXEL_BLACK),
  parameter                    INIT_FILE   = ""
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_write_en,
  input  logic [SEL_W-1:0]  i_write_sel,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_read_en,
  input  logic [SEL_W-1:0]  i_read_sel,
  input  logic [ADDR_W-1:0] i_read_addr,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_read_valid,
  input  logic              i_clear_req,
  input  logic [SEL_W-1:0]  i_clear_sel,
  output logic              o_clear_busy,
  output logic              o_clear_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TOTAL = NUM_SPRITES * DEPTH;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [DATA_W-1:0] r_mem [TOTAL];

  logic              w_clr_we_raw;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [SEL_W-1:0]  w_clr_sel;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_idx;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_rd_ok;
  logic [IDX_W-1:0]  w_rd_idx;

  sprite_clear_fsm #(
    .NUM_SPRITES (NUM_SPRITES),
    .SEL_W       (SEL_W),
    .ADDR_W      (ADDR_W)
  ) u_clr (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_clear_req (i_clear_req),
    .i_clear_sel (i_clear_sel),
    .o_clr_we    (w_clr_we_raw),
    .o_clr_addr  (w_clr_addr),
    .o_clr_sel   (w_clr_sel),
    .o_busy      (o_clear_busy),
    .o_done      (o_clear_done)
  );

  // reset aborts the clear before the in-flight word lands
  assign w_clr_we  = w_clr_we_raw && !i_Rst;
  assign w_clr_idx = IDX_W'({w_clr_sel, w_clr_addr});

  // the bank under clear is owned by the engine
  assign w_wr_ok  = i_write_en
                 && (int'(i_write_sel) < NUM_SPRITES)
                 && !(w_clr_we_raw && i_write_sel == w_clr_sel);
  assign w_wr_idx = IDX_W'({i_write_sel, i_write_addr});

  assign w_rd_ok  = int'(i_read_sel) < NUM_SPRITES;
  assign w_rd_idx = IDX_W'({i_read_sel, i_read_addr});

  // clear and external writes never target the same bank
  always_ff @(posedge i_Clk) begin
    if (w_wr_ok)
      r_mem[w_wr_idx] <= i_write_data;
    if (w_clr_we)
      r_mem[w_clr_idx] <= FILL_VALUE;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_read_data  <= '0;
      o_read_valid <= 1'b0;
    end else begin
      o_read_valid <= i_read_en;
      if (i_read_en) begin
        if (!w_rd_ok)
          o_read_data <= '0;
        else if (w_clr_we && w_rd_idx == w_clr_idx)
          o_read_data <= FILL_VALUE;
        else if (w_wr_ok && w_rd_idx == w_wr_idx)
          o_read_data <= i_write_data;
        else
          o_read_data <= r_mem[w_rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_bank.sv
// Directed self-checking bench for sprite_mem_bank.
// Covers write/read, write-first, clear, clear collisions, reset abort, bad sel.
module tb_sprite_mem_bank;

  localparam int SEL_W  = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0;
  logic [SEL_W-1:0]  wsel = '0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              re = 1'b0;
  logic [SEL_W-1:0]  rsel = '0;
  logic [ADDR_W-1:0] raddr = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              creq = 1'b0;
  logic [SEL_W-1:0]  csel = '0;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sprite_mem_bank #(
    .NUM_SPRITES (4),
    .SEL_W       (SEL_W),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FILL_VALUE  ('0)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_write_en   (we),
    .i_write_sel  (wsel),
    .i_write_addr (waddr),
    .i_write_data (wdata),
    .i_read_en    (re),
    .i_read_sel   (rsel),
    .i_read_addr  (raddr),
    .o_read_data  (rdata),
    .o_read_valid (rvalid),
    .i_clear_req  (creq),
    .i_clear_sel  (csel),
    .o_clear_busy (busy),
    .o_clear_done (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int a, input int d);
    we = 1'b1;
    wsel = SEL_W'(s);
    waddr = ADDR_W'(a);
    wdata = DATA_W'(d);
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input int s, input int a, input int exp);
    re = 1'b1;
    rsel = SEL_W'(s);
    raddr = ADDR_W'(a);
    tick();
    re = 1'b0;
    chk({tag, "_v"}, int'(rvalid), 1);
    chk(tag, int'(rdata), exp);
  endtask

  // returns bad word count versus the zero-fill image
  task automatic sweep(input int s, input int lim, output int errs);
    errs = 0;
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1;
      rsel = SEL_W'(s);
      raddr = ADDR_W'(a);
      tick();
      if (a < lim) begin
        if (rdata != '0) errs++;
      end else begin
        if (rdata != pat(a)) errs++;
      end
    end
    re = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'((a & 255) | 256);
  endfunction

  task automatic start_clear(input int s);
    creq = 1'b1;
    csel = SEL_W'(s);
    tick();
    creq = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, int'(done), 1);
  endtask

  int cyc;
  int errs;
  int seen_done;

  initial begin
    // reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_data", int'(rdata), 0);
    chk("rst_valid", int'(rvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // 1: basic write/read
    wr(1, 'h155, 'h07E);
    wr(2, 'h155, 'h1A5);
    rd("t1_b2", 2, 'h155, 'h1A5);
    rd("t1_b1", 1, 'h155, 'h07E);
    tick();
    chk("t1_vdrop", int'(rvalid), 0);
    chk("t1_hold", int'(rdata), 'h07E);

    // 2: same-cycle write + read
    we = 1'b1; wsel = 0; waddr = 7; wdata = 'h0F0;
    re = 1'b1; rsel = 0; raddr = 7;
    tick();
    we = 1'b0;
    re = 1'b0;
    chk("t2_wfirst", int'(rdata), 'h0F0);

    // 3: clear bank3
    wr(0, 3, 'h123);
    wr(3, 0, 'h1FF);
    wr(3, 512, 'h0AB);
    wr(3, 1023, 'h155);
    start_clear(3);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      tick();
    end
    chk("t3_busy_len", cyc, DEPTH);
    chk("t3_done", int'(done), 1);
    tick();
    chk("t3_done_1cyc", int'(done), 0);
    sweep(3, DEPTH, errs);
    chk("t3_zero", errs, 0);
    rd("t3_b0", 0, 3, 'h123);

    // 4: writes during clear of bank1
    wr(1, 5, 'h0AA);
    wr(1, 1000, 'h155);
    start_clear(1);
    repeat (10) tick();
    start_clear(2);
    chk("t4_busy", int'(busy), 1);
    wr(1, 5, 'h0AA);
    wr(0, 5, 'h0AA);
    rd("t4_old", 1, 1000, 'h155);
    wait_done("t4_done");
    rd("t4_b1", 1, 5, 0);
    rd("t4_b0", 0, 5, 'h0AA);
    rd("t4_b1_1000", 1, 1000, 0);
    rd("t4_b2", 2, 'h155, 'h1A5);

    // 5: reset mid-clear of bank2
    for (int a = 0; a < DEPTH; a++) wr(2, a, int'(pat(a)));
    start_clear(2);
    chk("t5_busy", int'(busy), 1);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy_off", int'(busy), 0);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen_done = 1;
      tick();
    end
    chk("t5_no_done", seen_done, 0);
    sweep(2, 100, errs);
    chk("t5_partial", errs, 0);

    // 6: out-of-range select
    wr(0, 'h155, 'h011);
    rd("t6_rd4", 4, 'h155, 0);
    wr(4, 'h155, 'h1FF);
    rd("t6_b0", 0, 'h155, 'h011);
    rd("t6_b1", 1, 'h155, 0);
    rd("t6_b2", 2, 'h155, int'(pat('h155)));
    rd("t6_b3", 3, 'h155, 0);
    start_clear(4);
    chk("t6_clr_ign", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
